jtframe_ba0_arb: RTL and testbench
==================================

# jtframe_ba0_arb

Round-robin arbiter that shares the SDRAM bank-0 read/write port of the board SDRAM controller between four game-side requesters, for example main CPU RAM, sub CPU RAM and two ROM fetchers. It sits between the game module and the board's `ba0_*` / `ba_*[0]` handshake signals. It grants one requester at a time, holds the grant until the controller signals `rdy`, and forwards the `ack`/`dst`/`dok`/`rdy` strobes only to the granted requester.

## Interface
- `AW`, 23: address width, equal to SDRAMW.
- `clk`  in  1: SDRAM clock domain (clk_rom).
- `rst`  in  1: synchronous, active-high reset.
- `req_addr`  in  4×AW: packed requester addresses; requester i occupies bits `[i*AW +: AW]`.
- `req_rd`  in  4: read requests, level, held until the matching `req_rdy`.
- `req_wr`  in  4: write requests, level, held until the matching `req_rdy`.
- `req_din`  in  4×16: write data per requester.
- `req_din_m`  in  4×2: write byte mask per requester, active-high enable.
- `req_ack`  out  4: controller accepted the granted request.
- `req_dst`  out  4: data start strobe.
- `req_dok`  out  4: `sdram_dout` valid for this requester.
- `req_rdy`  out  4: transaction complete.
- `ba0_addr`  out  AW: address to controller.
- `ba0_rd`  out  1: read request to controller.
- `ba0_wr`  out  1: write request to controller.
- `ba0_din`  out  16: write data to controller.
- `ba0_din_m`  out  2: write mask to controller.
- `ba0_ack`, `ba0_dst`, `ba0_dok`, `ba0_rdy`  in  1 each: controller strobes.
- `busy`  out  1: a grant is active.
- `wdog_err`  out  1: one-cycle watchdog abort pulse. Tied to 0 when `JTFRAME_BA0ARB_WDOG_EN` is undefined.

## Operation
- States:
  - IDLE: no grant.
  - REQ: `ba0_rd` or `ba0_wr` driven, waiting for `ba0_ack`.
  - XFER: request dropped, waiting for `ba0_rdy`.
- IDLE:
  - Pending vector p = `req_rd | req_wr`.
  - If p≠0, select the first set bit at or after pointer `ptr`, scanning upward with wrap 3→0.
  - Register grant index `gnt`, then go to REQ.
- The command latches at grant: addr, din, din_m, and op. If `req_wr[gnt]` is set, the op is write, even when `req_rd[gnt]` is also set.
- REQ:
  - Drive `ba0_rd` (read op) or `ba0_wr` (write op) from the latched command.
  - On `ba0_ack`, drop the request and go to XFER.
  - If `ba0_ack` and `ba0_rdy` arrive in the same cycle, go straight to IDLE.
- XFER: on `ba0_rdy`, go to IDLE and set `ptr` = `gnt`+1 mod 4.
- Strobe forwarding is combinational. `req_x[i]` = `ba0_x` & (state≠IDLE) & (`gnt`==i). Non-granted requesters never see strobes.
- Requesters not granted keep their request asserted; the arbiter never drops a pending request.
- A requester that drops its request before its grant loses its turn silently. After a grant, a dropped request is ignored until `rdy`.
- `busy` = (state≠IDLE).

## Timing
- Reset values:
  - All outputs 0.
  - `ptr`=0, `gnt`=0, state IDLE.
  - Reset mid-transaction aborts immediately. The controller shares `rst` and aborts too.
- Grant latency: request seen in IDLE at cycle n gives `ba0_rd`/`ba0_wr` high at n+1.
- Back-to-back: `ba0_rdy` at cycle n gives IDLE at n+1 and the next request out at n+2.
  - A requester must deassert its request on the cycle after `req_rdy`. Otherwise it is re-arbitrated as a new request.
- Starvation bound: a held request is granted within 3 other transactions.
- `ba0_addr`, `ba0_din` and `ba0_din_m` are registered. They are stable from grant until the next grant.

## Configuration
- `JTFRAME_BA0ARB_WDOG_EN` defined:
  - An 8-bit counter clears on entry to REQ and increments every cycle in REQ or XFER.
  - At count 255 without `ba0_rdy`, return to IDLE and pulse `wdog_err` for 1 cycle.
  - `req_rdy[gnt]` is not asserted on abort.
  - `ptr` advances past `gnt`, so a faulty requester cannot lock the port.
- Undefined: no counter, the arbiter waits indefinitely, and `wdog_err`=0.

## Test plan
- Single read: `req_rd[2]`=1, addr 0x012345. Required response: `ba0_rd`=1 next cycle with `ba0_addr`=0x012345; `ba0_ack` drops `ba0_rd`; `ba0_rdy` gives `req_rdy[2]`=1 for exactly 1 cycle; other `req_rdy` bits stay 0.
- Round robin: `req_rd`=4'b1111 held, each transaction answered. Required response: grant order 0,1,2,3,0 and `ptr` wraps.
- Write with mask: `req_wr[1]`=1 and `req_rd[1]`=1, din 0xBEEF, mask 2'b01. Required response: `ba0_wr`=1, `ba0_rd`=0, `ba0_din`=0xBEEF, `ba0_din_m`=2'b01.
- Same-cycle `ba0_ack`+`ba0_rdy` in REQ. Required response: state IDLE next cycle and the next pending request issued one cycle later.
- Reset asserted in XFER. Required response: all outputs 0 next cycle and `ptr`=0; after release, the first grant goes to the lowest pending index.
- With WDOG_EN: grant requester 3 and never assert `ba0_rdy`. Required response: `wdog_err` pulses 255 cycles after REQ entry, `req_rdy[3]` stays 0, and the pending `req_rd[0]` is granted next.

Source files
------------

// File: rtl/jtframe_ba0_arb.sv
// Round-robin arbiter sharing the SDRAM bank-0 port among four requesters.
// Optional watchdog abort is enabled with `define JTFRAME_BA0ARB_WDOG_EN.
module jtframe_ba0_arb #(
  parameter int AW = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4*AW-1:0]   req_addr,
  input  logic [3:0]        req_rd,
  input  logic [3:0]        req_wr,
  input  logic [63:0]       req_din,
  input  logic [7:0]        req_din_m,
  output logic [3:0]        req_ack,
  output logic [3:0]        req_dst,
  output logic [3:0]        req_dok,
  output logic [3:0]        req_rdy,
  output logic [AW-1:0]     ba0_addr,
  output logic              ba0_rd,
  output logic              ba0_wr,
  output logic [15:0]       ba0_din,
  output logic [1:0]        ba0_din_m,
  input  logic              ba0_ack,
  input  logic              ba0_dst,
  input  logic              ba0_dok,
  input  logic              ba0_rdy,
  output logic              busy,
  output logic              wdog_err
);

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  ptr_reg, ptr_next;
  logic [1:0]  gnt_reg;
  logic        op_wr_reg;
  logic [1:0]  sel;
  logic [3:0]  pend;
  logic        abort;

  // First pending index at or after base, wrapping 3 -> 0.
  function automatic logic [1:0] rr_pick(input logic [3:0] p, input logic [1:0] base);
    logic [1:0] r;
    logic [1:0] idx;
    r = base;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (p[idx]) r = idx;
    end
    return r;
  endfunction

  assign pend = req_rd | req_wr;
  assign sel  = rr_pick(pend, ptr_reg);
  assign busy = (state_reg != IDLE);

`ifdef JTFRAME_BA0ARB_WDOG_EN
  logic [7:0] wdog_cnt_reg;

  // Held at zero while idle, so it reads 0 on the first REQ cycle.
  always_ff @(posedge clk) begin
    if (rst || state_reg == IDLE) wdog_cnt_reg <= 8'd0;
    else                          wdog_cnt_reg <= wdog_cnt_reg + 8'd1;
  end

  assign abort = busy && (wdog_cnt_reg == 8'hff) && !ba0_rdy;
`else
  assign abort = 1'b0;
`endif

  assign wdog_err = abort;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (|pend) state_next = REQ;
      end
      REQ: begin
        if (abort || (ba0_ack && ba0_rdy)) begin
          state_next = IDLE;
          ptr_next   = gnt_reg + 2'd1;
        end else if (ba0_ack) begin
          state_next = XFER;
        end
      end
      XFER: begin
        if (abort || ba0_rdy) begin
          state_next = IDLE;
          ptr_next   = gnt_reg + 2'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= 2'd0;
      gnt_reg   <= 2'd0;
      op_wr_reg <= 1'b0;
      ba0_addr  <= '0;
      ba0_din   <= 16'd0;
      ba0_din_m <= 2'd0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      if (state_reg == IDLE && |pend) begin
        // Write wins when a requester raises both rd and wr.
        gnt_reg   <= sel;
        op_wr_reg <= req_wr[sel];
        ba0_addr  <= req_addr[int'(sel)*AW +: AW];
        ba0_din   <= req_din[{sel, 4'b0000} +: 16];
        ba0_din_m <= req_din_m[{sel, 1'b0} +: 2];
      end
    end
  end

  assign ba0_rd = (state_reg == REQ) && !op_wr_reg;
  assign ba0_wr = (state_reg == REQ) &&  op_wr_reg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_strobe
      logic mine;
      assign mine        = busy && (gnt_reg == 2'(gi));
      assign req_ack[gi] = ba0_ack & mine;
      assign req_dst[gi] = ba0_dst & mine;
      assign req_dok[gi] = ba0_dok & mine;
      assign req_rdy[gi] = ba0_rdy & mine;
    end
  endgenerate

endmodule

// File: tb/tb_jtframe_ba0_arb.sv
// Self-checking bench for jtframe_ba0_arb: transaction-level model plus directed tests.
module tb_jtframe_ba0_arb;
  localparam int AW = 23;
`ifdef JTFRAME_BA0ARB_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [4*AW-1:0] req_addr = '0;
  logic [3:0]      req_rd = '0, req_wr = '0;
  logic [63:0]     req_din = '0;
  logic [7:0]      req_din_m = '0;
  logic [3:0]      req_ack, req_dst, req_dok, req_rdy;
  logic [AW-1:0]   ba0_addr;
  logic            ba0_rd, ba0_wr;
  logic [15:0]     ba0_din;
  logic [1:0]      ba0_din_m;
  logic            ba0_ack = 1'b0, ba0_dst = 1'b0, ba0_dok = 1'b0, ba0_rdy = 1'b0;
  logic            busy, wdog_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jtframe_ba0_arb #(.AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_addr(req_addr), .req_rd(req_rd), .req_wr(req_wr),
    .req_din(req_din), .req_din_m(req_din_m),
    .req_ack(req_ack), .req_dst(req_dst), .req_dok(req_dok), .req_rdy(req_rdy),
    .ba0_addr(ba0_addr), .ba0_rd(ba0_rd), .ba0_wr(ba0_wr),
    .ba0_din(ba0_din), .ba0_din_m(ba0_din_m),
    .ba0_ack(ba0_ack), .ba0_dst(ba0_dst), .ba0_dok(ba0_dok), .ba0_rdy(ba0_rdy),
    .busy(busy), .wdog_err(wdog_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who holds the port, whether it was accepted,
  // the command captured at grant and the round-robin pointer.
  logic          m_busy = 1'b0, m_acked = 1'b0, m_wr = 1'b0;
  int            m_gnt = 0, m_ptr = 0, m_wait = 0;
  logic [AW-1:0] m_addr = '0;
  logic [15:0]   m_din = '0;
  logic [1:0]    m_mask = '0;

  function automatic int pick(input logic [3:0] p, input int base);
    for (int k = 0; k < 4; k++)
      if (p[(base + k) % 4]) return (base + k) % 4;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_acked <= 1'b0; m_wr <= 1'b0;
      m_gnt <= 0; m_ptr <= 0; m_wait <= 0;
      m_addr <= '0; m_din <= '0; m_mask <= '0;
    end else if (!m_busy) begin
      if ((req_rd | req_wr) != 4'd0) begin
        m_busy  <= 1'b1;
        m_acked <= 1'b0;
        m_gnt   <= pick(req_rd | req_wr, m_ptr);
        m_addr  <= req_addr[pick(req_rd | req_wr, m_ptr)*AW +: AW];
        m_din   <= req_din[pick(req_rd | req_wr, m_ptr)*16 +: 16];
        m_mask  <= req_din_m[pick(req_rd | req_wr, m_ptr)*2 +: 2];
        m_wr    <= req_wr[pick(req_rd | req_wr, m_ptr)];
        m_wait  <= 0;
      end
    end else if ((WDOG && m_wait == 255 && !ba0_rdy) || (ba0_rdy && (m_acked || ba0_ack))) begin
      m_busy  <= 1'b0;
      m_acked <= 1'b0;
      m_ptr   <= (m_gnt + 1) % 4;
    end else begin
      if (ba0_ack) m_acked <= 1'b1;
      m_wait <= m_wait + 1;
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("busy",      busy,      m_busy);
      chk("ba0_rd",    ba0_rd,    m_busy && !m_acked && !m_wr);
      chk("ba0_wr",    ba0_wr,    m_busy && !m_acked && m_wr);
      chk("ba0_addr",  ba0_addr,  m_addr);
      chk("ba0_din",   ba0_din,   m_din);
      chk("ba0_din_m", ba0_din_m, m_mask);
      chk("req_ack",   req_ack,   (m_busy && ba0_ack) ? (32'd1 << m_gnt) : 32'd0);
      chk("req_dst",   req_dst,   (m_busy && ba0_dst) ? (32'd1 << m_gnt) : 32'd0);
      chk("req_dok",   req_dok,   (m_busy && ba0_dok) ? (32'd1 << m_gnt) : 32'd0);
      chk("req_rdy",   req_rdy,   (m_busy && ba0_rdy) ? (32'd1 << m_gnt) : 32'd0);
      chk("wdog_err",  wdog_err,  WDOG && m_busy && m_wait == 255 && !ba0_rdy);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plays the controller: waits for a request, acks it, then signals rdy.
  task automatic do_txn(input bit same, output int idx, output int waited);
    waited = 0;
    idx = -1;
    while (!(ba0_rd || ba0_wr) && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if (!(ba0_rd || ba0_wr)) begin
      failures++;
      $display("FAIL txn_timeout actual=no_request required=request t=%0t", $time);
      return;
    end
    ba0_ack = 1'b1; ba0_dst = 1'b1; ba0_rdy = same; ba0_dok = same;
    #1;
    for (int i = 0; i < 4; i++) if (req_ack[i]) idx = i;
    tick();
    ba0_ack = 1'b0; ba0_dst = 1'b0; ba0_rdy = 1'b0; ba0_dok = 1'b0;
    if (!same) begin
      tick();
      ba0_rdy = 1'b1; ba0_dok = 1'b1;
      tick();
      ba0_rdy = 1'b0; ba0_dok = 1'b0;
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int i);
    return AW'(32'h100 * (i + 1) + 32'h7);
  endfunction

  int idx, waited, k;
  int rr_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_addr", ba0_addr, 0);
    chk("reset_rdy",  req_rdy, 0);

    // Strobes while idle must not reach anyone
    ba0_dst = 1'b1; ba0_dok = 1'b1;
    #1;
    chk("idle_dok", req_dok, 0);
    tick();
    ba0_dst = 1'b0; ba0_dok = 1'b0;

    // Round robin with all four held
    for (int i = 0; i < 4; i++) req_addr[i*AW +: AW] = addr_of(i);
    req_rd = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      do_txn(1'b0, idx, waited);
      chk($sformatf("rr_gnt%0d", t), idx, rr_order[t]);
      chk($sformatf("rr_lat%0d", t), waited, 1);
      $display("txn rr%0d granted=%0d waited=%0d", t, idx, waited);
    end
    req_rd = 4'b0000;
    tick();

    // Single read from requester 2
    req_addr[2*AW +: AW] = 23'h012345;
    req_rd[2] = 1'b1;
    tick();
    chk("sr_rd", ba0_rd, 1);
    chk("sr_addr", ba0_addr, 23'h012345);
    ba0_ack = 1'b1;
    tick();
    ba0_ack = 1'b0;
    chk("sr_rd_drop", ba0_rd, 0);
    tick();
    ba0_rdy = 1'b1;
    #1;
    chk("sr_rdy", req_rdy, 4'b0100);
    tick();
    ba0_rdy = 1'b0;
    req_rd[2] = 1'b0;
    chk("sr_rdy_pulse", req_rdy, 0);
    tick();
    chk("sr_idle", busy, 0);
    $display("txn single_read addr=%0h", 23'h012345);
    req_addr[2*AW +: AW] = addr_of(2);

    // Write with mask, rd also raised
    req_din[1*16 +: 16] = 16'hBEEF;
    req_din_m[1*2 +: 2] = 2'b01;
    req_wr[1] = 1'b1;
    req_rd[1] = 1'b1;
    tick();
    chk("wr_wr", ba0_wr, 1);
    chk("wr_rd", ba0_rd, 0);
    chk("wr_din", ba0_din, 16'hBEEF);
    chk("wr_mask", ba0_din_m, 2'b01);
    do_txn(1'b0, idx, waited);
    chk("wr_gnt", idx, 1);
    req_wr = 4'b0000;
    req_rd = 4'b0000;
    $display("txn write granted=%0d din=beef mask=01", idx);
    tick();

    // Reset while in XFER (pointer sits at 2 before the reset)
    req_rd[2] = 1'b1;
    tick();
    ba0_ack = 1'b1;
    tick();
    ba0_ack = 1'b0;
    req_rd = 4'b1001;
    rst = 1'b1;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_rd", ba0_rd, 0);
    chk("rst_addr", ba0_addr, 0);
    rst = 1'b0;
    tick();
    chk("rst_first_addr", ba0_addr, addr_of(0));
    do_txn(1'b0, idx, waited);
    chk("rst_first_gnt", idx, 0);
    req_rd[0] = 1'b0;
    $display("txn reset_recover granted=%0d", idx);

    // Same-cycle ack+rdy, requester 3 still pending
    req_rd[1] = 1'b1;
    do_txn(1'b1, idx, waited);
    chk("same_gnt", idx, 1);
    req_rd[1] = 1'b0;
    chk("same_idle", busy, 0);
    tick();
    chk("same_next_rd", ba0_rd, 1);
    chk("same_next_addr", ba0_addr, addr_of(3));
    do_txn(1'b0, idx, waited);
    chk("same_next_gnt", idx, 3);
    req_rd[3] = 1'b0;
    $display("txn same_cycle then granted=%0d", idx);
    tick();

`ifdef JTFRAME_BA0ARB_WDOG_EN
    // Requester 3 is never answered
    req_rd = 4'b1000;
    tick();
    req_rd[0] = 1'b1;
    k = 0;
    while (!wdog_err && k < 300) begin
      tick();
      k++;
    end
    chk("wdog_delay", k, 255);
    chk("wdog_rdy", req_rdy, 0);
    tick();
    req_rd[3] = 1'b0;
    chk("wdog_idle", busy, 0);
    tick();
    chk("wdog_next_addr", ba0_addr, addr_of(0));
    do_txn(1'b0, idx, waited);
    chk("wdog_next_gnt", idx, 0);
    req_rd = 4'b0000;
    $display("txn watchdog delay=%0d next=%0d", k, idx);
`endif

    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
